mux4_rr_arbiter: RTL and testbench

Round-robin arbiter that shares the 4-to-1 gate-level multiplexer between four requesters. It drives the mux select lines (`s1`, `s0`) so that the output carries the current owner's input. It returns a one-hot grant to each requester. Each grant is bounded by a programmable hold limit so that no requester can starve the others.

---
 rtl/mux4_rr_arbiter_if.sv | 11 +
 rtl/mux4_rr_arbiter.sv | 73 +++++++
 tb/tb_mux4_rr_arbiter.sv | 123 ++++++++++++
 3 files changed

// File: rtl/mux4_rr_arbiter_if.sv
// mux4_rr_arbiter_if: request/grant and mux-select bundle between requesters and the arbiter
interface mux4_rr_arbiter_if #(parameter int CNT_W = 4);
  logic [3:0] req;
  logic [3:0] gnt;
  logic s1;
  logic s0;
  logic busy;
  logic [CNT_W-1:0] hold_cnt;
  modport master(output req, input gnt, s1, s0, busy, hold_cnt);
  modport slave(input req, output gnt, s1, s0, busy, hold_cnt);
endinterface

// File: rtl/mux4_rr_arbiter.sv
// mux4_rr_arbiter: round-robin owner of a 4-to-1 mux with a per-grant hold limit
module mux4_rr_arbiter #(
  parameter int MAX_HOLD = 8,
  parameter int CNT_W = 4
) (
  input logic clk,
  input logic rst,
  mux4_rr_arbiter_if.slave bus
);
  if (MAX_HOLD < 0 || MAX_HOLD > (1 << CNT_W) - 1) begin : g_bad_max_hold
    $error("MAX_HOLD must lie in 0..2**CNT_W-1");
  end
  typedef enum logic {IDLE, GRANT} state_t;
  localparam logic [CNT_W-1:0] LIM = CNT_W'(MAX_HOLD);
  localparam logic [CNT_W-1:0] TOP = '1;
  state_t state, state_n;
  logic [1:0] last, last_n, sel, sel_n, win;
  logic [3:0] gnt, gnt_n;
  logic [CNT_W-1:0] hold_cnt, hold_n;
  logic keep;
  function automatic logic [1:0] pick(input logic [3:0] r, input logic [1:0] b);
    logic [1:0] i;
    pick = b;
    for (int k = 4; k >= 1; k--) begin
      i = b + 2'(k);
      if (r[i]) pick = i;
    end
  endfunction
  // owner keeps the mux while requesting and under the limit; otherwise re-arbitrate with the owner ranked last
  always_comb begin
    win = pick(bus.req, last);
    keep = state == GRANT && bus.req[last] && (MAX_HOLD == 0 || hold_cnt < LIM);
    state_n = state;
    last_n = last;
    sel_n = sel;
    gnt_n = gnt;
    hold_n = hold_cnt;
    if (keep) begin
      hold_n = (hold_cnt == TOP) ? hold_cnt : hold_cnt + 1'b1;
    end else if (|bus.req) begin
      state_n = GRANT;
      last_n = win;
      sel_n = win;
      gnt_n = 4'b0001 << win;
      hold_n = CNT_W'(1);
    end else begin
      state_n = IDLE;
      gnt_n = '0;
      hold_n = '0;
    end
  end
  // state, pointer and registered outputs; reset leaves requester 0 first in line
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      last <= 2'd3;
      sel <= 2'd0;
      gnt <= '0;
      hold_cnt <= '0;
    end else begin
      state <= state_n;
      last <= last_n;
      sel <= sel_n;
      gnt <= gnt_n;
      hold_cnt <= hold_n;
    end
  end
  assign bus.gnt = gnt;
  assign bus.s1 = sel[1];
  assign bus.s0 = sel[0];
  assign bus.busy = |gnt;
  assign bus.hold_cnt = hold_cnt;
endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// tb_mux4_rr_arbiter: directed and random checks of two arbiter instances against a reference model
module tb_mux4_rr_arbiter;
  logic clk = 0;
  logic rst = 1;
  int n_cmp = 0;
  int n_bad = 0;
  int m_own[2], m_last[2], m_cnt[2], m_sel[2];
  int lim[2] = '{8, 0};
  int gc[4];
  mux4_rr_arbiter_if #(.CNT_W(4)) b0 ();
  mux4_rr_arbiter_if #(.CNT_W(4)) b1 ();
  mux4_rr_arbiter #(.MAX_HOLD(8), .CNT_W(4)) dut0 (.clk(clk), .rst(rst), .bus(b0.slave));
  mux4_rr_arbiter #(.MAX_HOLD(0), .CNT_W(4)) dut1 (.clk(clk), .rst(rst), .bus(b1.slave));
  always #5 clk = ~clk;
  task automatic check(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask
  function automatic int pick(input logic [3:0] r, input int l);
    for (int k = 1; k <= 4; k++) if (r[(l + k) % 4]) return (l + k) % 4;
    return -1;
  endfunction
  task automatic model_step(input int d, input logic [3:0] r, input logic rs);
    int w;
    if (rs) begin
      m_own[d] = -1; m_last[d] = 3; m_cnt[d] = 0; m_sel[d] = 0;
    end else if (m_own[d] >= 0 && r[m_own[d]] && (lim[d] == 0 || m_cnt[d] < lim[d])) begin
      m_cnt[d] = m_cnt[d] < 15 ? m_cnt[d] + 1 : 15;
    end else begin
      w = pick(r, m_last[d]);
      if (w >= 0) begin
        m_own[d] = w; m_last[d] = w; m_sel[d] = w; m_cnt[d] = 1;
      end else begin
        m_own[d] = -1; m_cnt[d] = 0;
      end
    end
  endtask
  task automatic cmp_dut(input int d, input logic [3:0] g, input logic [1:0] s, input logic b, input int h);
    int eg;
    eg = m_own[d] < 0 ? 0 : 1 << m_own[d];
    check($sformatf("d%0d_gnt", d), int'(g), eg);
    check($sformatf("d%0d_sel", d), int'(s), m_sel[d]);
    check($sformatf("d%0d_busy", d), int'(b), int'(eg != 0));
    check($sformatf("d%0d_hold", d), h, m_cnt[d]);
  endtask
  task automatic cyc(input logic [3:0] r, input logic rs);
    b0.req = r;
    b1.req = r;
    rst = rs;
    @(posedge clk);
    model_step(0, r, rs);
    model_step(1, r, rs);
    #1;
    cmp_dut(0, b0.gnt, {b0.s1, b0.s0}, b0.busy, int'(b0.hold_cnt));
    cmp_dut(1, b1.gnt, {b1.s1, b1.s0}, b1.busy, int'(b1.hold_cnt));
  endtask
  initial begin
    logic [3:0] r;
    b0.req = '0;
    b1.req = '0;
    cyc(4'b0000, 1);
    cyc(4'b0000, 1);
    check("rst_gnt", int'(b0.gnt), 0);
    check("rst_sel", int'({b0.s1, b0.s0}), 0);
    check("rst_busy", int'(b0.busy), 0);
    check("rst_hold", int'(b0.hold_cnt), 0);
    cyc(4'b0001, 0);
    check("first_gnt", int'(b0.gnt), 1);
    check("first_hold", int'(b0.hold_cnt), 1);
    check("first_busy", int'(b0.busy), 1);
    cyc(4'b0000, 0);
    check("drop_gnt", int'(b0.gnt), 0);
    check("drop_sel", int'({b0.s1, b0.s0}), 0);
    gc = '{0, 0, 0, 0};
    for (int i = 0; i < 32; i++) begin
      cyc(4'b1111, 0);
      for (int k = 0; k < 4; k++) if (b0.gnt[k]) gc[k]++;
      if (i == 0) check("fair_first", int'(b0.gnt), 4'b0010);
    end
    for (int k = 0; k < 4; k++) check($sformatf("fair_share%0d", k), gc[k], 8);
    cyc(4'b0000, 0);
    cyc(4'b0100, 0);
    check("own2_gnt", int'(b0.gnt), 4'b0100);
    cyc(4'b1001, 0);
    check("switch_gnt", int'(b0.gnt), 4'b1000);
    check("switch_sel", int'({b0.s1, b0.s0}), 3);
    check("switch_hold", int'(b0.hold_cnt), 1);
    cyc(4'b0000, 0);
    for (int i = 0; i < 20; i++) begin
      cyc(4'b0010, 0);
      check("solo_gnt", int'(b0.gnt), 4'b0010);
      check("solo_hold", int'(b0.hold_cnt), (i % 8) + 1);
    end
    cyc(4'b0000, 0);
    check("solo_end_hold", int'(b0.hold_cnt), 0);
    cyc(4'b0000, 1);
    for (int i = 0; i < 40; i++) begin
      cyc(4'b0011, 0);
      check("nolim_gnt", int'(b1.gnt), 4'b0001);
    end
    check("nolim_sat", int'(b1.hold_cnt), 15);
    cyc(4'b0000, 0);
    cyc(4'b1000, 0);
    cyc(4'b1111, 0);
    cyc(4'b1111, 0);
    check("own3_gnt", int'(b0.gnt), 4'b1000);
    cyc(4'b1111, 1);
    check("midrst_gnt", int'(b0.gnt), 0);
    check("midrst_sel", int'({b0.s1, b0.s0}), 0);
    cyc(4'b1111, 0);
    check("postrst_gnt", int'(b0.gnt), 4'b0001);
    r = 4'b0000;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 3) == 0) r = 4'($urandom_range(0, 15));
      cyc(r, $urandom_range(0, 79) == 0);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
